// File: rtl/hmac_sha256_prf_pkg.sv
// Shared SHA-256 constants, HMAC pad bytes, FSM state type and round helper functions
// for the PBKDF2 pseudo-random function.
package pbkdf2_pkg;

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [7:0]  IPAD_BYTE = 8'h36;
  localparam logic [7:0]  OPAD_BYTE = 8'h5c;
  localparam logic [63:0] LEN_768   = 64'h300;

  typedef enum logic [2:0] {IDLE, INNER0, INNER1, OUTER0, OUTER1, DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Second block of a 96-byte message: 32 data bytes, 0x80 terminator, zeros, bit length.
  function automatic logic [511:0] msg_block(input logic [255:0] m);
    return {m, 8'h80, 184'h0, LEN_768};
  endfunction

  function automatic logic [511:0] key_block(input logic [255:0] k, input logic [7:0] pad);
    return {k ^ {32{pad}}, {32{pad}}};
  endfunction

endpackage

// File: rtl/hmac_sha256_prf_if.sv
// Request/response handshake bundle between the PBKDF2 chunk and the HMAC responder.
interface hmac_sha256_prf_if;
  logic [255:0] key_i;
  logic [255:0] msg_i;
  logic         in_v_i;
  logic         in_r_o;
  logic [255:0] hash_o;
  logic         out_v_o;
  logic         out_r_i;

  modport master (output key_i, msg_i, in_v_i, out_r_i, input in_r_o, hash_o, out_v_o);
  modport slave  (input key_i, msg_i, in_v_i, out_r_i, output in_r_o, hash_o, out_v_o);
endinterface

// File: rtl/hmac_sha256_prf_compress.sv
// One SHA-256 block compression, one round per cycle with a 16-word rolling schedule.
// Round 0 runs on the start edge itself so back-to-back compressions chain every 65 cycles.
module sha256_compress
  import pbkdf2_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start,
  input  logic [511:0] block_i,
  input  logic [255:0] state_i,
  output logic [255:0] digest_o,
  output logic         done_o
);

  logic [0:15][31:0] w, cw, nw;
  logic [0:7][31:0]  v, cv, nv, hv, ff;
  logic [6:0]        cnt;
  logic              busy;
  logic [5:0]        kidx;
  logic [31:0]       t1, t2;

  always_comb begin
    cw   = start ? block_i : w;
    cv   = start ? state_i : v;
    kidx = start ? 6'd0 : cnt[5:0];
    t1   = cv[7] + bsig1(cv[4]) + ch(cv[4], cv[5], cv[6]) + SHA256_K[kidx] + cw[0];
    t2   = bsig0(cv[0]) + maj(cv[0], cv[1], cv[2]);
    nv   = {t1 + t2, cv[0], cv[1], cv[2], cv[3] + t1, cv[4], cv[5], cv[6]};
    nw   = {cw[1:15], ssig1(cw[14]) + cw[9] + ssig0(cw[1]) + cw[0]};
    for (int i = 0; i < 8; i++) ff[i] = hv[i] + v[i];
  end

  // cnt 1..63 are rounds, cnt 64 is the feed-forward cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w        <= '0;
      v        <= '0;
      hv       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done_o   <= 1'b0;
      digest_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (start) begin
        v    <= nv;
        w    <= nw;
        hv   <= state_i;
        cnt  <= 7'd1;
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt == 7'd64) begin
          digest_o <= ff;
          done_o   <= 1'b1;
          busy     <= 1'b0;
        end else begin
          v   <= nv;
          w   <= nw;
          cnt <= cnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/hmac_sha256_prf.sv
// HMAC-SHA256 over a 32-byte key and 32-byte message, with an optional cache of the
// inner/outer key midstates so repeated keys need only two compressions.
module hmac_sha256_prf
  import pbkdf2_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  hmac_sha256_prf_if.slave  bus
);

  state_t       state, nstate;
  logic [255:0] key_q, msg_q, imid_q, idig_q, hash_q;
  logic [255:0] cache_key, cache_imid, cache_omid;
  logic         cache_valid, hit_q;
  logic         in_r, accept, hit_now;
  logic         start, done;
  logic [511:0] blk;
  logic [255:0] st, digest;

  sha256_compress u_compress (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start    (start),
    .block_i  (blk),
    .state_i  (st),
    .digest_o (digest),
    .done_o   (done)
  );

  assign in_r        = (state == IDLE) && !rst_i;
  assign accept      = in_r && bus.in_v_i;
  assign hit_now     = KEY_CACHE && cache_valid && (bus.key_i == cache_key);
  assign bus.in_r_o  = in_r;
  assign bus.out_v_o = (state == DONE);
  assign bus.hash_o  = hash_q;

  // Each stage launches the next compression in the same cycle its own result appears.
  always_comb begin
    nstate = state;
    start  = 1'b0;
    blk    = '0;
    st     = '0;
    case (state)
      IDLE: if (accept) begin
        start = 1'b1;
        if (hit_now) begin
          nstate = INNER1;
          st     = cache_imid;
          blk    = msg_block(bus.msg_i);
        end else begin
          nstate = INNER0;
          st     = SHA256_IV;
          blk    = key_block(bus.key_i, IPAD_BYTE);
        end
      end
      INNER0: if (done) begin
        start  = 1'b1;
        nstate = INNER1;
        st     = digest;
        blk    = msg_block(msg_q);
      end
      INNER1: if (done) begin
        start = 1'b1;
        if (hit_q) begin
          nstate = OUTER1;
          st     = cache_omid;
          blk    = msg_block(digest);
        end else begin
          nstate = OUTER0;
          st     = SHA256_IV;
          blk    = key_block(key_q, OPAD_BYTE);
        end
      end
      OUTER0: if (done) begin
        start  = 1'b1;
        nstate = OUTER1;
        st     = digest;
        blk    = msg_block(idig_q);
      end
      OUTER1: if (done) nstate = DONE;
      DONE:   if (bus.out_r_i) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      key_q       <= '0;
      msg_q       <= '0;
      imid_q      <= '0;
      idig_q      <= '0;
      hash_q      <= '0;
      hit_q       <= 1'b0;
      cache_key   <= '0;
      cache_imid  <= '0;
      cache_omid  <= '0;
      cache_valid <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        key_q <= bus.key_i;
        msg_q <= bus.msg_i;
        hit_q <= hit_now;
      end
      if (state == INNER0 && done) imid_q <= digest;
      if (state == INNER1 && done) idig_q <= digest;
      if (state == OUTER0 && done && KEY_CACHE) begin
        cache_key   <= key_q;
        cache_imid  <= imid_q;
        cache_omid  <= digest;
        cache_valid <= 1'b1;
      end
      if (state == OUTER1 && done) hash_q <= digest;
    end
  end

endmodule

// File: tb/tb_hmac_sha256_prf.sv
// Directed bench for hmac_sha256_prf: standalone compression vector, miss/hit latency,
// backpressure, mid-run reset and the cache-disabled variant against a reference model.
module tb_hmac_sha256_prf;
  import pbkdf2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hmac_sha256_prf_if bus1();
  hmac_sha256_prf_if bus0();

  hmac_sha256_prf #(.KEY_CACHE(1'b1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));
  hmac_sha256_prf #(.KEY_CACHE(1'b0)) dut_nc (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));

  logic         c_start;
  logic [511:0] c_block;
  logic [255:0] c_state, c_digest;
  logic         c_done;

  sha256_compress u_cmp (
    .clk_i(clk), .rst_i(rst), .start(c_start), .block_i(c_block),
    .state_i(c_state), .digest_o(c_digest), .done_o(c_done)
  );

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] M1 = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
  localparam logic [255:0] M2 = {256{1'b1}};
  localparam logic [255:0] K2 = K1 ^ 256'h1;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  // Independent reference: full 64-word schedule, straight from the SHA-256 definition.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] s, input logic [511:0] b);
    logic [31:0] w [0:63];
    logic [31:0] a, bb, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    {a, bb, c, d, e, f, g, h} = s;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA256_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {a + s[255:224], bb + s[223:192], c + s[191:160], d + s[159:128],
            e + s[127:96], f + s[95:64], g + s[63:32], h + s[31:0]};
  endfunction

  function automatic logic [255:0] ref_hmac(input logic [255:0] k, input logic [255:0] m);
    logic [255:0] iv, imid, omid, idig;
    iv   = SHA256_IV;
    imid = ref_compress(iv, {k ^ {32{8'h36}}, {32{8'h36}}});
    omid = ref_compress(iv, {k ^ {32{8'h5c}}, {32{8'h5c}}});
    idig = ref_compress(imid, {m, 8'h80, 184'h0, 64'h300});
    return ref_compress(omid, {idig, 8'h80, 184'h0, 64'h300});
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus0.in_r_o : bus1.in_r_o;
  endfunction

  function automatic logic ovl(input bit sel);
    return sel ? bus0.out_v_o : bus1.out_v_o;
  endfunction

  // Issue one request (sel=1 targets the cache-less instance), return latency and digest.
  task automatic applyStimulus(input bit sel, input logic [255:0] k, input logic [255:0] m,
                               output int lat, output logic [255:0] h);
    int guard = 0;
    while (!rdy(sel) && guard < 20) begin @(posedge clk); #1; guard++; end
    if (sel) begin bus0.key_i = k; bus0.msg_i = m; bus0.in_v_i = 1'b1; end
    else     begin bus1.key_i = k; bus1.msg_i = m; bus1.in_v_i = 1'b1; end
    @(posedge clk); #1;
    if (sel) begin bus0.in_v_i = 1'b0; bus0.key_i = ~k; bus0.msg_i = ~m; end
    else     begin bus1.in_v_i = 1'b0; bus1.key_i = ~k; bus1.msg_i = ~m; end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ovl(sel) && lat < 400);
    h = sel ? bus0.hash_o : bus1.hash_o;
  endtask

  task automatic release_out(input bit sel, input string tag);
    if (sel) bus0.out_r_i = 1'b1; else bus1.out_r_i = 1'b1;
    @(posedge clk); #1;
    if (sel) bus0.out_r_i = 1'b0; else bus1.out_r_i = 1'b0;
    checkOutput(tag, rdy(sel), 1);
  endtask

  initial begin
    int lat, cnt;
    logic [255:0] h, h_first;

    bus1.key_i = '0; bus1.msg_i = '0; bus1.in_v_i = 1'b0; bus1.out_r_i = 1'b0;
    bus0.key_i = '0; bus0.msg_i = '0; bus0.in_v_i = 1'b0; bus0.out_r_i = 1'b0;
    c_start = 1'b0; c_block = '0; c_state = '0;

    // Reset values
    #1 rst = 1'b1;
    #10;
    checkOutput("rst_in_r", bus1.in_r_o, 0);
    checkOutput("rst_out_v", bus1.out_v_o, 0);
    checkOutput("rst_hash", bus1.hash_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_r_after_rst", bus1.in_r_o, 1);

    // Standalone compression of padded "abc"
    c_block = {32'h61626380, 416'h0, 64'h18};
    c_state = SHA256_IV;
    c_start = 1'b1;
    cnt = 0;
    do begin @(posedge clk); #1; c_start = 1'b0; cnt++; end while (!c_done && cnt < 100);
    checkOutput("cmp_latency", cnt, 65);
    checkOutput("cmp_abc", c_digest, ABC_DIGEST);

    // Miss, then hit, then one-bit key change
    applyStimulus(0, K1, M1, lat, h);
    checkOutput("miss_lat", lat, 260);
    checkOutput("miss_hash", h, ref_hmac(K1, M1));
    release_out(0, "miss_release");
    applyStimulus(0, K1, M2, lat, h);
    checkOutput("hit_lat", lat, 130);
    checkOutput("hit_hash", h, ref_hmac(K1, M2));
    release_out(0, "hit_release");
    applyStimulus(0, K2, M1, lat, h);
    checkOutput("newkey_lat", lat, 260);
    checkOutput("newkey_hash", h, ref_hmac(K2, M1));

    // Backpressure: digest held, ready low, stray requests ignored
    for (int i = 0; i < 50; i++) begin
      bus1.key_i = K1; bus1.msg_i = M2; bus1.in_v_i = i[0];
      @(posedge clk); #1;
      checkOutput("bp_hash", bus1.hash_o, ref_hmac(K2, M1));
      checkOutput("bp_ready_valid", {bus1.in_r_o, bus1.out_v_o}, 2'b01);
    end
    bus1.in_v_i = 1'b0;
    release_out(0, "bp_release");
    applyStimulus(0, K2, M2, lat, h);
    checkOutput("bp_hit_lat", lat, 130);
    checkOutput("bp_hit_hash", h, ref_hmac(K2, M2));
    release_out(0, "bp_hit_release");

    // Reset at cycle 100 of a miss run
    bus1.key_i = K1; bus1.msg_i = M1; bus1.in_v_i = 1'b1;
    @(posedge clk); #1 bus1.in_v_i = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_v", bus1.out_v_o, 0);
    checkOutput("midrst_hash", bus1.hash_o, 0);
    checkOutput("midrst_in_r", bus1.in_r_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, K2, M1, lat, h);
    checkOutput("postrst_lat", lat, 260);
    checkOutput("postrst_hash", h, ref_hmac(K2, M1));
    release_out(0, "postrst_release");
    applyStimulus(0, K2, M1, lat, h);
    checkOutput("postrst_hit_lat", lat, 130);
    checkOutput("postrst_hit_hash", h, ref_hmac(K2, M1));
    release_out(0, "postrst_hit_release");

    // Cache disabled: identical requests both take the full path
    applyStimulus(1, K1, M1, lat, h_first);
    checkOutput("nc_lat1", lat, 260);
    checkOutput("nc_hash1", h_first, ref_hmac(K1, M1));
    release_out(1, "nc_release1");
    applyStimulus(1, K1, M1, lat, h);
    checkOutput("nc_lat2", lat, 260);
    checkOutput("nc_hash2", h, h_first);
    release_out(1, "nc_release2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/hmac_sha256_prf.md
# hmac_sha256_prf

Fixed-geometry HMAC-SHA256 responder serving as the pseudo-random function for the PBKDF2 chunk. It accepts a 256-bit key (password) and a 256-bit message (salt or previous U value) over a valid/ready handshake and returns the 256-bit HMAC over a second valid/ready handshake. It sits directly below `PBKDF2_chunk`, which issues one request per iteration with a constant key. An optional key-midstate cache halves latency for repeated keys.

## Interface
- `KEY_CACHE`, default 1: 1 enables reuse of inner/outer key midstates when `key_i` repeats; 0 always runs four compressions.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `key_i` in 256: HMAC key; bits [255:248] are byte 0.
- `msg_i` in 256: message, same byte order.
- `in_v_i` in 1: request valid.
- `in_r_o` out 1: request ready.
- `hash_o` out 256: HMAC digest; [255:224] = H0 … [31:0] = H7.
- `out_v_o` out 1: digest valid.
- `out_r_i` in 1: digest consumed.

## Operation
- States: IDLE, INNER0, INNER1, OUTER0, OUTER1, DONE.
- IDLE: `in_r_o`=1. On `in_v_i & in_r_o`, capture `key_i`/`msg_i`. Later input changes are ignored.
  - With cache hit (`KEY_CACHE`=1, cache valid, captured key == stored key), go to INNER1.
  - Otherwise go to INNER0.
- INNER0: compress (K‖0²⁵⁶) XOR 0x36-repeated from SHA-256 IV, giving inner midstate.
- INNER1: compress msg‖0x80‖0…‖64-bit length 0x300 from the inner midstate, giving inner digest.
- OUTER0: compress (K‖0²⁵⁶) XOR 0x5c-repeated from IV, giving outer midstate. On a cache hit, skip OUTER0 and load the stored outer midstate.
- OUTER1: compress inner digest‖0x80‖0…‖0x300 from the outer midstate. Result goes to `hash_o`. Enter DONE.
- Cache update: after a non-hit run finishes OUTER0, store the key, inner midstate and outer midstate, and set cache valid.
- DONE: `out_v_o`=1, and `hash_o` is stable. On `out_r_i`, go to IDLE.
- Arithmetic: all word additions are mod 2³². The message schedule is a 16-word rolling window. Round constants come from the package.

## Timing
- Each compression takes exactly 65 cycles: 64 rounds at one per cycle, plus 1 feed-forward add.
- Latency from the accept edge to the first cycle with `out_v_o`=1:
  - 260 cycles without a cache hit.
  - 130 cycles with a cache hit.
- `in_r_o` is low in every state except IDLE. There is no same-cycle pass-through: the DONE→IDLE handshake raises `in_r_o` on the following cycle.
- `out_v_o` holds until `out_r_i`. `out_r_i` outside DONE has no effect.
- Reset values:
  - `in_r_o`=0 while `rst_i` is asserted, then 1 from the first cycle after deassertion.
  - `out_v_o`=0.
  - `hash_o`=0.
  - cache valid=0.
  - FSM=IDLE.
- Reset mid-operation aborts immediately with no output. The cache is invalidated even if it was just written.
- Back-to-back requests with the same key after a flush: the first request is a miss, the second a hit.

## Structure
- `pbkdf2_pkg` holds:
  - SHA256_K[0:63] and SHA256_IV[0:7].
  - IPAD_BYTE = 0x36 and OPAD_BYTE = 0x5c.
  - LEN_768 = 64'h300.
  - The FSM state enum.
  - The 32-bit rotate/Σ/σ/Ch/Maj functions.
- Sub-module `sha256_compress` contains:
  - Ports: `start`, `block_i[511:0]`, `state_i[255:0]`, `digest_o[255:0]`, `done_o`.
  - 65-cycle fixed latency and its own round counter.
- The top level holds the FSM, input capture, block muxing and the cache registers.

## Test plan
- `sha256_compress` alone:
  - Input: block "abc" padded (0x61626380, zeros, length 0x18) from the IV.
  - Expected: `digest_o` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, and `done_o` exactly 65 cycles after `start`.
- Miss path:
  - Input: key = 0x00..1f, msg = 0x20..3f.
  - Expected: `hash_o` equals the Python `hmac.new(key,msg,sha256)` result, and `out_v_o` exactly 260 cycles after accept.
- Hit path:
  - Input: repeat the same key with msg = all 0xff.
  - Expected: `hash_o` matches the model, latency 130.
  - Then change the key by one bit: expect latency 260 and a correct digest.
- Backpressure:
  - Hold `out_r_i`=0 for 50 cycles.
  - Expected: `hash_o` stable, `in_r_o`=0 throughout, and `in_v_i` pulses ignored. After release, `in_r_o`=1 on the next cycle.
- Reset mid-run:
  - Assert `rst_i` at cycle 100 of a miss run.
  - Expected: `out_v_o`/`hash_o` go to 0 asynchronously. The next request with the same key takes 260 cycles.
- `KEY_CACHE`=0:
  - Input: two identical requests.
  - Expected: both take 260 cycles and produce identical digests.
